// File: rtl/qpi_flash_pkg.sv
// Shared definitions for the QPI flash responder: command opcodes, the
// decoder state encoding and the dummy-clock lookup used by SET_PARAMS.
package qpi_flash_pkg;

  localparam logic [7:0] OP_SPI_EXIT_CR    = 8'hFF;
  localparam logic [7:0] OP_ENTER_QPI      = 8'h38;
  localparam logic [7:0] OP_SET_PARAMS     = 8'hC0;
  localparam logic [7:0] OP_FAST_READ_QUAD = 8'hEB;
  localparam logic [7:0] OP_EXIT_QPI       = 8'hFF;
  localparam logic [7:0] OP_JEDEC_ID       = 8'h9F;

  typedef enum logic [2:0] {
    ST_CMD,
    ST_ADDR,
    ST_MODE,
    ST_DUMMY,
    ST_DATA,
    ST_CFG,
    ST_IGNORE
  } state_t;

  // Parameter byte bits [5:4] select the total number of mode+dummy clocks.
  function automatic logic [3:0] dummy_lut(input logic [1:0] sel);
    case (sel)
      2'd0:    return 4'd2;
      2'd1:    return 4'd4;
      2'd2:    return 4'd6;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/qpi_flash_responder_if.sv
// Flash pin bundle plus the byte-wide fetch port of the QPI flash responder.
// slave is the responder side, master is the initiator/memory side.
interface qpi_flash_responder_if;
  logic        flash_nCE;
  logic        flash_SCK;
  logic [3:0]  flash_IO_in;
  logic [3:0]  flash_IO_out;
  logic [3:0]  flash_IO_oe;
  logic [23:0] mem_addr;
  logic        mem_req;
  logic [7:0]  mem_data;

  modport slave (
    input  flash_nCE, flash_SCK, flash_IO_in, mem_data,
    output flash_IO_out, flash_IO_oe, mem_addr, mem_req
  );

  modport master (
    output flash_nCE, flash_SCK, flash_IO_in, mem_data,
    input  flash_IO_out, flash_IO_oe, mem_addr, mem_req
  );
endinterface

// File: rtl/qpi_resp_sync.sv
// Input synchroniser for the flash pins: SYNC_STAGES flops per input, then
// single-clk rise/fall pulses for SCK and nCE on the synchronised values.
module qpi_resp_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       nce_in,
  input  logic       sck_in,
  input  logic [3:0] io_in,
  output logic       nce,
  output logic       nce_rise,
  output logic       nce_fall,
  output logic       sck_rise,
  output logic       sck_fall,
  output logic [3:0] io
);

  logic [SYNC_STAGES-1:0]      nce_sr;
  logic [SYNC_STAGES-1:0]      sck_sr;
  logic [SYNC_STAGES-1:0][3:0] io_sr;
  logic                        nce_d;
  logic                        sck_d;

  // Control synchroniser chains: deselected and SCK low out of reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      nce_sr <= '1;
      sck_sr <= '0;
      nce_d  <= 1'b1;
      sck_d  <= 1'b0;
    end else begin
      nce_sr[0] <= nce_in;
      sck_sr[0] <= sck_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        nce_sr[i] <= nce_sr[i-1];
        sck_sr[i] <= sck_sr[i-1];
      end
      nce_d <= nce_sr[SYNC_STAGES-1];
      sck_d <= sck_sr[SYNC_STAGES-1];
    end
  end

  // IO data chain carries no reset; it is only consumed on SCK edges.
  always_ff @(posedge clk) begin
    io_sr[0] <= io_in;
    for (int i = 1; i < SYNC_STAGES; i++) io_sr[i] <= io_sr[i-1];
  end

  assign nce      = nce_sr[SYNC_STAGES-1];
  assign nce_rise =  nce_sr[SYNC_STAGES-1] & ~nce_d;
  assign nce_fall = ~nce_sr[SYNC_STAGES-1] &  nce_d;
  assign sck_rise =  sck_sr[SYNC_STAGES-1] & ~sck_d;
  assign sck_fall = ~sck_sr[SYNC_STAGES-1] &  sck_d;
  assign io       = io_sr[SYNC_STAGES-1];

endmodule

// File: rtl/qpi_flash_responder.sv
// QPI flash target: decodes the reset/config/read command stream and answers
// quad reads from a byte-wide memory port, oversampling flash_SCK with clk.
// Optional feature macro: QPI_RESP_JEDEC_ID_EN enables the QPI 0x9F JEDEC ID read.
module qpi_flash_responder
  import qpi_flash_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter int          MEM_LATENCY = 1,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4018
) (
  input  logic                        clk,
  input  logic                        reset_n,
  qpi_flash_responder_if.slave        bus,
  output logic                        qpi_mode,
  output logic                        cont_read
);

`ifdef QPI_RESP_JEDEC_ID_EN
  localparam bit JEDEC_EN = 1'b1;
`else
  localparam bit JEDEC_EN = 1'b0;
`endif

  logic        nce, nce_rise, nce_fall, sck_rise, sck_fall;
  logic [3:0]  io;
  state_t      state_q, state_nx;
  logic [3:0]  cnt_q, cnt_nx, cnt_last;
  logic [22:0] sh_q;
  logic [23:0] sh_in;
  logic        qpi_mode_q, cont_read_q, pend_qpi_q;
  logic [3:0]  dummy_clks_q;
  logic [23:0] addr_q;
  logic [7:0]  data_q;
  logic [3:0]  lo_q, io_out_q, oe_q;
  logic        lo_phase_q, mem_req_q, jedec_q;
  logic [1:0]  jidx_q;
  logic [MEM_LATENCY-1:0] req_p;
  logic        cmd_pend_qpi, cmd_exit_qpi, cmd_clr_cont;
  logic        cfg_load, mode_load, addr_load, jedec_go;
  logic        data_fall, hi_fall, lo_fall, fetch_next;

  qpi_resp_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .nce_in   (bus.flash_nCE),
    .sck_in   (bus.flash_SCK),
    .io_in    (bus.flash_IO_in),
    .nce      (nce),
    .nce_rise (nce_rise),
    .nce_fall (nce_fall),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .io       (io)
  );

  function automatic logic [7:0] jedec_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return JEDEC_ID[23:16];
      2'd1:    return JEDEC_ID[15:8];
      default: return JEDEC_ID[7:0];
    endcase
  endfunction

  // Shift value as it will be after the current SCK rise.
  assign sh_in = qpi_mode_q ? {sh_q[19:0], io} : {sh_q[22:0], io[0]};

  assign data_fall  = sck_fall && !nce && (state_q == ST_DATA);
  assign hi_fall    = data_fall && !lo_phase_q;
  assign lo_fall    = data_fall &&  lo_phase_q;
  assign fetch_next = hi_fall && !jedec_q;

  // Next-state decode: phase lengths counted in SCK rises, commands decoded on the last one.
  always_comb begin
    state_nx     = state_q;
    cnt_nx       = cnt_q;
    cmd_pend_qpi = 1'b0;
    cmd_exit_qpi = 1'b0;
    cmd_clr_cont = 1'b0;
    cfg_load     = 1'b0;
    mode_load    = 1'b0;
    addr_load    = 1'b0;
    jedec_go     = 1'b0;
    case (state_q)
      ST_CMD:   cnt_last = qpi_mode_q ? 4'd1 : 4'd7;
      ST_ADDR:  cnt_last = 4'd5;
      ST_DUMMY: cnt_last = dummy_clks_q - 4'd3;
      default:  cnt_last = 4'd1;
    endcase
    if (nce) begin
      state_nx = ST_CMD;
      cnt_nx   = 4'd0;
    end else if (nce_fall) begin
      state_nx = cont_read_q ? ST_ADDR : ST_CMD;
      cnt_nx   = 4'd0;
    end else if (sck_rise) begin
      cnt_nx = cnt_q + 4'd1;
      case (state_q)
        ST_CMD: if (cnt_q == cnt_last) begin
          cnt_nx   = 4'd0;
          state_nx = ST_IGNORE;
          if (qpi_mode_q) begin
            case (sh_in[7:0])
              OP_EXIT_QPI:       cmd_exit_qpi = 1'b1;
              OP_SET_PARAMS:     state_nx = ST_CFG;
              OP_FAST_READ_QUAD: state_nx = ST_ADDR;
              OP_JEDEC_ID: if (JEDEC_EN) begin
                state_nx = ST_DATA;
                jedec_go = 1'b1;
              end
              default: ;
            endcase
          end else begin
            case (sh_in[7:0])
              OP_ENTER_QPI:   cmd_pend_qpi = 1'b1;
              OP_SPI_EXIT_CR: cmd_clr_cont = 1'b1;
              default: ;
            endcase
          end
        end
        ST_ADDR: if (cnt_q == cnt_last) begin
          cnt_nx    = 4'd0;
          state_nx  = ST_MODE;
          addr_load = 1'b1;
        end
        ST_MODE: if (cnt_q == cnt_last) begin
          cnt_nx    = 4'd0;
          mode_load = 1'b1;
          state_nx  = (dummy_clks_q == 4'd2) ? ST_DATA : ST_DUMMY;
        end
        ST_DUMMY: if (cnt_q == cnt_last) begin
          cnt_nx   = 4'd0;
          state_nx = ST_DATA;
        end
        ST_CFG: if (cnt_q == cnt_last) begin
          cnt_nx   = 4'd0;
          cfg_load = 1'b1;
          state_nx = ST_IGNORE;
        end
        default: cnt_nx = cnt_q;
      endcase
    end
  end

  // FSM state and phase counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_CMD;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_nx;
      cnt_q   <= cnt_nx;
    end
  end

  // Configuration: survives nCE, cleared only by reset_n; QPI entry waits for deselect.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      qpi_mode_q   <= 1'b0;
      cont_read_q  <= 1'b0;
      dummy_clks_q <= 4'd2;
      pend_qpi_q   <= 1'b0;
    end else begin
      if (nce_rise) begin
        if (pend_qpi_q) qpi_mode_q <= 1'b1;
        pend_qpi_q <= 1'b0;
      end
      if (cmd_pend_qpi) pend_qpi_q <= 1'b1;
      if (cmd_exit_qpi) begin
        qpi_mode_q  <= 1'b0;
        cont_read_q <= 1'b0;
      end
      if (cmd_clr_cont) cont_read_q <= 1'b0;
      if (mode_load)    cont_read_q <= (sh_in[5:4] == 2'b10);
      if (cfg_load)     dummy_clks_q <= dummy_lut(sh_in[5:4]);
    end
  end

  // Output drive, fetch strobe and read-data sequencing.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      io_out_q   <= 4'h0;
      oe_q       <= 4'h0;
      mem_req_q  <= 1'b0;
      lo_phase_q <= 1'b0;
      jedec_q    <= 1'b0;
      jidx_q     <= 2'd0;
      req_p      <= '0;
    end else begin
      mem_req_q <= addr_load || fetch_next;
      req_p[0]  <= mem_req_q;
      for (int i = 1; i < MEM_LATENCY; i++) req_p[i] <= req_p[i-1];
      if (nce)            oe_q <= 4'h0;
      else if (data_fall) oe_q <= 4'hF;
      if (hi_fall) io_out_q <= data_q[7:4];
      if (lo_fall) io_out_q <= lo_q;
      if (nce || state_q != ST_DATA) lo_phase_q <= 1'b0;
      else if (data_fall)            lo_phase_q <= ~lo_phase_q;
      if (nce)           jedec_q <= 1'b0;
      else if (jedec_go) jedec_q <= 1'b1;
      if (jedec_go)                jidx_q <= 2'd1;
      else if (hi_fall && jedec_q) jidx_q <= (jidx_q == 2'd2) ? 2'd0 : jidx_q + 2'd1;
    end
  end

  // Datapath: shift register, fetch address and the byte being shifted out.
  always_ff @(posedge clk) begin
    if (sck_rise && !nce) sh_q <= sh_in[22:0];
    if (addr_load)       addr_q <= sh_in;
    else if (fetch_next) addr_q <= addr_q + 24'd1;
    if (jedec_go)                    data_q <= jedec_byte(2'd0);
    else if (hi_fall && jedec_q)     data_q <= jedec_byte(jidx_q);
    else if (req_p[MEM_LATENCY-1])   data_q <= bus.mem_data;
    if (hi_fall) lo_q <= data_q[3:0];
  end

  // Raw nCE gates the drivers so the bus is released without synchroniser delay.
  assign bus.flash_IO_oe  = bus.flash_nCE ? 4'h0 : oe_q;
  assign bus.flash_IO_out = io_out_q;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_req      = mem_req_q;
  assign qpi_mode         = qpi_mode_q;
  assign cont_read        = cont_read_q;

endmodule

// File: tb/tb_qpi_flash_responder.sv
// Directed bench for qpi_flash_responder: drives the initiator side of the
// flash link and a one-cycle-latency memory model.
module tb_qpi_flash_responder;

  localparam int HP = 8;

  logic clk;
  logic reset_n;
  logic qpi_mode;
  logic cont_read;
  int   tests  = 0;
  int   failed = 0;
  logic [23:0] reqs[$];
  logic [3:0]  rv, roe;

  qpi_flash_responder_if bus();

  qpi_flash_responder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .qpi_mode  (qpi_mode),
    .cont_read (cont_read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] memval(input logic [23:0] a);
    case (a)
      24'h123454: return 8'hAB;
      24'h123455: return 8'hCD;
      24'hFFFFFF: return 8'h5A;
      24'h000000: return 8'hC3;
      default:    return a[7:0] ^ 8'h3C;
    endcase
  endfunction

  // Memory model: record each fetch and answer one clk later.
  always @(negedge clk) begin
    if (bus.mem_req) begin
      reqs.push_back(bus.mem_addr);
      bus.mem_data <= memval(bus.mem_addr);
    end
  end

  function automatic logic [31:0] qaddr(input int i);
    if (i < reqs.size()) return {8'h00, reqs[i]};
    return 32'hDEAD_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic [3:0] n);
    bus.flash_IO_in = n;
    tick(HP);
    bus.flash_SCK = 1'b1;
    tick(HP);
    bus.flash_SCK = 1'b0;
  endtask

  task automatic rd(output logic [3:0] v, output logic [3:0] oe);
    tick(HP);
    v  = bus.flash_IO_out;
    oe = bus.flash_IO_oe;
    bus.flash_SCK = 1'b1;
    tick(HP);
    bus.flash_SCK = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] exp_v, input logic [3:0] exp_oe);
    logic [3:0] v, oe;
    rd(v, oe);
    chk({tag, "_oe"}, {28'h0, oe}, {28'h0, exp_oe});
    if (exp_oe != 4'h0) chk({tag, "_io"}, {28'h0, v}, {28'h0, exp_v});
  endtask

  task automatic sel();
    bus.flash_nCE = 1'b0;
    tick(4);
  endtask

  task automatic desel();
    tick(4);
    bus.flash_nCE = 1'b1;
    tick(12);
  endtask

  task automatic spi_byte(input logic [7:0] b);
    sel();
    for (int i = 7; i >= 0; i--) cyc({3'b000, b[i]});
    desel();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n          = 1'b0;
    bus.flash_nCE    = 1'b1;
    bus.flash_SCK    = 1'b0;
    bus.flash_IO_in  = 4'h0;
    bus.mem_data     = 8'h00;
    tick(4);
    chk("rst_qpi_mode",  {31'h0, qpi_mode}, 32'h0);
    chk("rst_cont_read", {31'h0, cont_read}, 32'h0);
    chk("rst_oe",        {28'h0, bus.flash_IO_oe}, 32'h0);
    chk("rst_io_out",    {28'h0, bus.flash_IO_out}, 32'h0);
    chk("rst_mem_req",   {31'h0, bus.mem_req}, 32'h0);
    chk("rst_dummy",     {28'h0, dut.dummy_clks_q}, 32'd2);
    reset_n = 1'b1;
    tick(4);

    // Initiator reset sequence.
    spi_byte(8'hFF);
    sel(); cyc(4'hF); cyc(4'hF); desel();
    spi_byte(8'h38);
    chk("seq_qpi_mode", {31'h0, qpi_mode}, 32'h1);
    sel(); cyc(4'hC); cyc(4'h0); cyc(4'h2); cyc(4'h0); desel();
    chk("seq_dummy6", {28'h0, dut.dummy_clks_q}, 32'd6);
    reqs.delete();
    sel();
    cyc(4'hE); cyc(4'hB);
    cyc(4'h0); cyc(4'h0); cyc(4'h0); cyc(4'h0); cyc(4'h0); cyc(4'h3);
    cyc(4'h2); cyc(4'h0);
    for (int i = 0; i < 4; i++) cyc(4'h0);
    desel();
    chk("seq_mem_addr", qaddr(0), 32'h0000_0003);
    chk("seq_cont_read", {31'h0, cont_read}, 32'h1);

    // Continuous read: address first, no command byte.
    reqs.delete();
    sel();
    cyc(4'h1); cyc(4'h2); cyc(4'h3); cyc(4'h4); cyc(4'h5); cyc(4'h4);
    cyc(4'h2); cyc(4'h0);
    for (int i = 0; i < 4; i++) cyc(4'h0);
    rd_chk("cr_n0", 4'hA, 4'hF);
    rd_chk("cr_n1", 4'hB, 4'hF);
    rd_chk("cr_n2", 4'hC, 4'hF);
    rd_chk("cr_n3", 4'hD, 4'hF);
    chk("cr_addr0", qaddr(0), 32'h0012_3454);
    chk("cr_addr1", qaddr(1), 32'h0012_3455);
    bus.flash_nCE = 1'b1;
    tick(1);
    chk("cr_oe_release", {28'h0, bus.flash_IO_oe}, 32'h0);
    tick(12);
    chk("cr_still_armed", {31'h0, cont_read}, 32'h1);

    // Continuous read at the top of the address space, M=00 disarms.
    reqs.delete();
    sel();
    for (int i = 0; i < 6; i++) cyc(4'hF);
    cyc(4'h0); cyc(4'h0);
    for (int i = 0; i < 4; i++) cyc(4'h0);
    rd_chk("wrap_n0", 4'h5, 4'hF);
    rd_chk("wrap_n1", 4'hA, 4'hF);
    desel();
    chk("wrap_addr0", qaddr(0), 32'h00FF_FFFF);
    chk("wrap_addr1", qaddr(1), 32'h0000_0000);
    chk("wrap_cont_read", {31'h0, cont_read}, 32'h0);

    // Next transaction must be decoded as a command again.
    reqs.delete();
    sel();
    cyc(4'hE); cyc(4'hB);
    cyc(4'h0); cyc(4'h0); cyc(4'h0); cyc(4'h1); cyc(4'h0); cyc(4'h0);
    cyc(4'h0); cyc(4'h0);
    desel();
    chk("cmd_again_addr", qaddr(0), 32'h0000_0100);

    // Abort in the middle of the address phase.
    reqs.delete();
    sel();
    cyc(4'hE); cyc(4'hB); cyc(4'h1); cyc(4'h2); cyc(4'h3);
    bus.flash_nCE = 1'b1;
    tick(1);
    chk("abort_oe", {28'h0, bus.flash_IO_oe}, 32'h0);
    tick(12);
    chk("abort_no_req", reqs.size(), 32'd0);
    sel(); cyc(4'hF); cyc(4'hF); desel();
    chk("exit_qpi", {31'h0, qpi_mode}, 32'h0);

    // Reset pulse in the middle of a data phase.
    spi_byte(8'h38);
    chk("reenter_qpi", {31'h0, qpi_mode}, 32'h1);
    sel();
    cyc(4'hE); cyc(4'hB);
    cyc(4'h1); cyc(4'h2); cyc(4'h3); cyc(4'h4); cyc(4'h5); cyc(4'h4);
    cyc(4'h2); cyc(4'h0);
    for (int i = 0; i < 4; i++) cyc(4'h0);
    rd_chk("pre_rst_n0", 4'hA, 4'hF);
    rd_chk("pre_rst_n1", 4'hB, 4'hF);
    chk("pre_rst_cont", {31'h0, cont_read}, 32'h1);
    reset_n = 1'b0;
    tick(1);
    chk("mid_rst_qpi_mode",  {31'h0, qpi_mode}, 32'h0);
    chk("mid_rst_cont_read", {31'h0, cont_read}, 32'h0);
    chk("mid_rst_oe",        {28'h0, bus.flash_IO_oe}, 32'h0);
    chk("mid_rst_io_out",    {28'h0, bus.flash_IO_out}, 32'h0);
    chk("mid_rst_mem_req",   {31'h0, bus.mem_req}, 32'h0);
    chk("mid_rst_dummy",     {28'h0, dut.dummy_clks_q}, 32'd2);
    reset_n = 1'b1;
    bus.flash_nCE = 1'b1;
    tick(12);

    // JEDEC ID read in QPI mode.
    spi_byte(8'h38);
    sel();
    cyc(4'h9); cyc(4'hF);
`ifdef QPI_RESP_JEDEC_ID_EN
    rd_chk("jedec_0", 4'hE, 4'hF);
    rd_chk("jedec_1", 4'hF, 4'hF);
    rd_chk("jedec_2", 4'h4, 4'hF);
    rd_chk("jedec_3", 4'h0, 4'hF);
    rd_chk("jedec_4", 4'h1, 4'hF);
    rd_chk("jedec_5", 4'h8, 4'hF);
    rd_chk("jedec_6", 4'hE, 4'hF);
    rd_chk("jedec_7", 4'hF, 4'hF);
`else
    for (int i = 0; i < 4; i++) rd_chk("jedec_off", 4'h0, 4'h0);
`endif
    desel();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
